agu_addr_gen: RTL and testbench
===============================

// Module: agu_addr_gen
// PURPOSE
// Address generation unit of the out-of-order pipeline's memory path. Takes one
// load/store micro-op per cycle from register read, computes the effective address
// rs1+imm, derives byte enables and lane-aligned store data, and flags misalignment.
// Registers the result into one pipeline stage that feeds the load/store unit and the
// store buffer.
// PARAMETERS
// XLEN       32  data/address width in bits
// ROB_TAG_W   5  reorder-buffer index width
// PRF_W       6  physical register index width
// PORTS
// clk             in   1          clock
// rst             in   1          reset; asynchronous, active-high
// stall           in   1          pipeline stall from control/recovery; hold output stage
// flush           in   1          mispredict/exception recovery; kill in-flight op
// in_valid        in   1          micro-op valid from register read
// in_is_store     in   1          1=store, 0=load
// in_size         in   2          00=byte, 01=half, 10=word (11 reserved)
// in_unsigned     in   1          load zero-extend (LBU/LHU); carried through
// in_rs1          in   XLEN       base register value
// in_rs2          in   XLEN       store data register value
// in_imm          in   XLEN       sign-extended 12-bit offset
// in_rob_tag      in   ROB_TAG_W  ROB entry of the op
// in_prd          in   PRF_W      load destination physical register
// out_valid       out  1          registered op valid toward LSU/store buffer
// out_is_store    out  1          registered in_is_store
// out_size        out  2          registered in_size
// out_unsigned    out  1          registered in_unsigned
// out_addr        out  XLEN       effective address rs1+imm (mod 2^XLEN)
// out_byte_en     out  4          byte lane enables
// out_store_data  out  XLEN       store data shifted into byte lanes
// out_misaligned  out  1          address misaligned for size
// out_rob_tag     out  ROB_TAG_W  registered in_rob_tag
// out_prd         out  PRF_W      registered in_prd
// BEHAVIOUR
// - Latency 1: op captured on rising clk when in_valid=1, stall=0, flush=0.
// - Reset: all outputs 0 immediately on rst assertion, held until rst deasserts.
// - flush=1 at a clk edge: out_valid<=0 regardless of stall or in_valid; flush wins.
// - stall=1 (flush=0): every output register holds; new input dropped (upstream holds).
// - stall=0, in_valid=0: out_valid<=0; other out_* fields unchanged (don't-care).
// - addr = in_rs1 + in_imm, XLEN-bit wrap-around, no overflow detection.
// - Byte lane: lo = addr[1:0].
// - byte: byte_en = 4'b0001<<lo; store_data = {4{rs2[7:0]}}.
// - half: byte_en = 4'b0011<<lo[1]*2; store_data = {2{rs2[15:0]}}.
// - word: byte_en = 4'b1111; store_data = rs2.
// - size 11: treated as word.
// - misaligned: half with addr[0]=1, or word with addr[1:0]!=0; then byte_en=0.
// - When misaligned, out_valid still 1 so the ROB can raise the exception.
// - Loads: store_data=0; byte_en computed identically, so the LSU uses it for
//   hit checks.
// - Purely combinational datapath ahead of a single output register bank; no FSM.
// TESTING
// - Reset: assert rst mid-cycle with valid op registered -> all outputs 0
//   asynchronously.
// - LW rs1=0x1000, imm=0x10 -> next cycle out_valid=1, addr=0x1010, byte_en=1111,
//   misaligned=0.
// - SB rs1=0x2003, imm=0, rs2=0xAABBCCDD -> addr=0x2003, byte_en=1000,
//   store_data=0xDDDDDDDD.
// - SH rs1=0xFFFFFFFE, imm=4 -> addr=0x00000002 (wrap), byte_en=1100,
//   store_data=0xCCDDCCDD.
// - LW addr 0x1001 -> misaligned=1, byte_en=0000, out_valid=1.
// - Sequence op A, stall=1 with op B present, then flush=1 -> A held during stall,
//   B never appears, out_valid=0 after flush.

Source files
------------

// File: rtl/agu_addr_gen_if.sv
// Load/store micro-op bus between register read, the AGU and the LSU.
// Control (stall/flush) travels with the bus so one port carries the whole stage.
interface agu_addr_gen_if #(
  parameter int XLEN      = 32,
  parameter int ROB_TAG_W = 5,
  parameter int PRF_W     = 6
);
  logic                 stall;
  logic                 flush;
  logic                 in_valid;
  logic                 in_is_store;
  logic [1:0]           in_size;
  logic                 in_unsigned;
  logic [XLEN-1:0]      in_rs1;
  logic [XLEN-1:0]      in_rs2;
  logic [XLEN-1:0]      in_imm;
  logic [ROB_TAG_W-1:0] in_rob_tag;
  logic [PRF_W-1:0]     in_prd;

  logic                 out_valid;
  logic                 out_is_store;
  logic [1:0]           out_size;
  logic                 out_unsigned;
  logic [XLEN-1:0]      out_addr;
  logic [3:0]           out_byte_en;
  logic [XLEN-1:0]      out_store_data;
  logic                 out_misaligned;
  logic [ROB_TAG_W-1:0] out_rob_tag;
  logic [PRF_W-1:0]     out_prd;

  modport slave (
    input  stall, flush,
    input  in_valid, in_is_store, in_size, in_unsigned,
    input  in_rs1, in_rs2, in_imm, in_rob_tag, in_prd,
    output out_valid, out_is_store, out_size, out_unsigned,
    output out_addr, out_byte_en, out_store_data,
    output out_misaligned, out_rob_tag, out_prd
  );

  modport master (
    output stall, flush,
    output in_valid, in_is_store, in_size, in_unsigned,
    output in_rs1, in_rs2, in_imm, in_rob_tag, in_prd,
    input  out_valid, out_is_store, out_size, out_unsigned,
    input  out_addr, out_byte_en, out_store_data,
    input  out_misaligned, out_rob_tag, out_prd
  );
endinterface

// File: rtl/agu_addr_gen.sv
// Address generation: rs1+imm, lane byte enables, lane-replicated store data,
// misalignment flag, all behind one registered stage toward the LSU.
module agu_addr_gen #(
  parameter int XLEN      = 32,
  parameter int ROB_TAG_W = 5,
  parameter int PRF_W     = 6
) (
  input  logic           clk,
  input  logic           rst,
  agu_addr_gen_if.slave  io_agu
);

  logic [XLEN-1:0]      w_addr;
  logic [1:0]           w_lo;
  logic [3:0]           w_be_raw;
  logic [3:0]           w_byte_en;
  logic [XLEN-1:0]      w_store_data;
  logic                 w_misaligned;
  logic                 w_capture;

  logic                 r_valid;
  logic                 r_is_store;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic [XLEN-1:0]      r_addr;
  logic [3:0]           r_byte_en;
  logic [XLEN-1:0]      r_store_data;
  logic                 r_misaligned;
  logic [ROB_TAG_W-1:0] r_rob_tag;
  logic [PRF_W-1:0]     r_prd;

  assign w_addr = io_agu.in_rs1 + io_agu.in_imm;
  assign w_lo   = w_addr[1:0];

  // Size 11 is reserved and falls into the word arm.
  always_comb begin
    w_be_raw     = 4'b1111;
    w_store_data = io_agu.in_rs2;
    w_misaligned = 1'b0;
    case (io_agu.in_size)
      2'b00: begin
        w_be_raw     = 4'b0001 << w_lo;
        w_store_data = {(XLEN/8){io_agu.in_rs2[7:0]}};
      end
      2'b01: begin
        w_be_raw     = w_lo[1] ? 4'b1100 : 4'b0011;
        w_store_data = {(XLEN/16){io_agu.in_rs2[15:0]}};
        w_misaligned = w_lo[0];
      end
      default: begin
        w_be_raw     = 4'b1111;
        w_store_data = io_agu.in_rs2;
        w_misaligned = |w_lo;
      end
    endcase
  end

  // Loads keep byte enables for LSU hit checks but carry no data.
  assign w_byte_en = w_misaligned ? 4'b0000 : w_be_raw;
  assign w_capture = io_agu.in_valid & ~io_agu.stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_is_store   <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_byte_en    <= 4'b0000;
      r_store_data <= '0;
      r_misaligned <= 1'b0;
      r_rob_tag    <= '0;
      r_prd        <= '0;
    end else if (io_agu.flush) begin
      r_valid <= 1'b0;
    end else if (!io_agu.stall) begin
      r_valid <= io_agu.in_valid;
      if (w_capture) begin
        r_is_store   <= io_agu.in_is_store;
        r_size       <= io_agu.in_size;
        r_unsigned   <= io_agu.in_unsigned;
        r_addr       <= w_addr;
        r_byte_en    <= w_byte_en;
        r_store_data <= io_agu.in_is_store ? w_store_data : '0;
        r_misaligned <= w_misaligned;
        r_rob_tag    <= io_agu.in_rob_tag;
        r_prd        <= io_agu.in_prd;
      end
    end
  end

  assign io_agu.out_valid      = r_valid;
  assign io_agu.out_is_store   = r_is_store;
  assign io_agu.out_size       = r_size;
  assign io_agu.out_unsigned   = r_unsigned;
  assign io_agu.out_addr       = r_addr;
  assign io_agu.out_byte_en    = r_byte_en;
  assign io_agu.out_store_data = r_store_data;
  assign io_agu.out_misaligned = r_misaligned;
  assign io_agu.out_rob_tag    = r_rob_tag;
  assign io_agu.out_prd        = r_prd;

endmodule

// File: tb/tb_agu_addr_gen.sv
// Scoreboard bench for agu_addr_gen: expected results queued at drive time,
// popped one cycle later when the registered stage presents them.
module tb_agu_addr_gen;

  typedef struct packed {
    logic        v;
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] sd;
    logic        mis;
    logic [4:0]  tag;
    logic [5:0]  prd;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_t q[$];

  agu_addr_gen_if bus ();

  agu_addr_gen dut (
    .clk    (clk),
    .rst    (rst),
    .io_agu (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t model(
    input logic st, input logic [1:0] sz, input logic un,
    input logic [31:0] rs1, input logic [31:0] rs2,
    input logic [31:0] imm, input logic [4:0] tag,
    input logic [5:0] prd);
    res_t r;
    int n;
    int lo;
    int base;
    r = '0;
    r.v = 1'b1; r.st = st; r.sz = sz; r.un = un;
    r.tag = tag; r.prd = prd;
    r.addr = rs1 + imm;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    lo = int'(r.addr[1:0]);
    r.mis = (lo % n) != 0;
    base = lo - (lo % n);
    for (int i = 0; i < 4; i++) begin
      if (!r.mis && i >= base && i < base + n) r.be[i] = 1'b1;
      if (st) r.sd[8*i +: 8] = rs2[8*(i % n) +: 8];
    end
    return r;
  endfunction

  function automatic res_t sample();
    return {bus.out_valid, bus.out_is_store, bus.out_size,
            bus.out_unsigned, bus.out_addr, bus.out_byte_en,
            bus.out_store_data, bus.out_misaligned,
            bus.out_rob_tag, bus.out_prd};
  endfunction

  task automatic put(input logic st, input logic [1:0] sz,
                     input logic un, input logic [31:0] rs1,
                     input logic [31:0] rs2, input logic [31:0] imm,
                     input logic [4:0] tag, input logic [5:0] prd);
    bus.in_valid    = 1'b1;
    bus.in_is_store = st;
    bus.in_size     = sz;
    bus.in_unsigned = un;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_imm      = imm;
    bus.in_rob_tag  = tag;
    bus.in_prd      = prd;
    if (!bus.stall && !bus.flush)
      q.push_back(model(st, sz, un, rs1, rs2, imm, tag, prd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_t obs;
    bus.stall = 0; bus.flush = 0; bus.in_valid = 0;
    bus.in_is_store = 0; bus.in_size = 0; bus.in_unsigned = 0;
    bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_imm = 0;
    bus.in_rob_tag = 0; bus.in_prd = 0;
    #1 rst = 1'b1;
    #1;
    obs = sample();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset got %h exp 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    obs = sample();
    checks++;
    if (obs.v !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_valid got %b exp 0", obs.v);
    end
  endtask

  task automatic test_directed();
    res_t obs, exp;
    string nm;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin nm = "lw";      put(0, 2'b10, 0, 32'h1000, 32'h0, 32'h10, 5'd1, 6'd7); end
        1: begin nm = "sb";      put(1, 2'b00, 0, 32'h2003, 32'hAABBCCDD, 32'h0, 5'd2, 6'd0); end
        2: begin nm = "sh_wrap"; put(1, 2'b01, 0, 32'hFFFFFFFE, 32'hAABBCCDD, 32'h4, 5'd3, 6'd0); end
        3: begin nm = "lw_mis";  put(0, 2'b10, 0, 32'h1000, 32'h0, 32'h1, 5'd4, 6'd9); end
        default: begin nm = "lhu_mis"; put(0, 2'b01, 1, 32'h1002, 32'h0, 32'hFFFFFFFF, 5'd5, 6'd10); end
      endcase
      tick();
      obs = sample();
      exp = q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s got %h exp %h", nm, obs, exp);
      end
      checks++;
      case (k)
        0: if (obs.addr !== 32'h1010 || obs.be !== 4'b1111 || obs.mis !== 1'b0) begin
             errors++; $display("FAIL lw_const got %h/%b exp 1010/1111", obs.addr, obs.be); end
        1: if (obs.be !== 4'b1000 || obs.sd !== 32'hDDDDDDDD) begin
             errors++; $display("FAIL sb_const got %b/%h exp 1000/dddddddd", obs.be, obs.sd); end
        2: if (obs.addr !== 32'h2 || obs.be !== 4'b1100 || obs.sd !== 32'hCCDDCCDD) begin
             errors++; $display("FAIL sh_const got %h/%b/%h exp 2/1100/ccddccdd", obs.addr, obs.be, obs.sd); end
        3: if (obs.v !== 1'b1 || obs.mis !== 1'b1 || obs.be !== 4'b0000) begin
             errors++; $display("FAIL lw_mis_const got v%b m%b be%b exp v1 m1 be0000", obs.v, obs.mis, obs.be); end
        default: if (obs.mis !== 1'b1 || obs.un !== 1'b1) begin
             errors++; $display("FAIL lhu_const got m%b u%b exp m1 u1", obs.mis, obs.un); end
      endcase
    end
    bus.in_valid = 0;
  endtask

  task automatic test_stall_flush();
    res_t obs, expa;
    put(1, 2'b10, 0, 32'h3000, 32'h12345678, 32'h8, 5'd11, 6'd0);
    tick();
    expa = q.pop_front();
    obs = sample();
    checks++;
    if (obs !== expa) begin
      errors++; $display("FAIL op_a got %h exp %h", obs, expa);
    end
    bus.stall = 1;
    put(0, 2'b00, 0, 32'h4000, 32'h0, 32'h5, 5'd12, 6'd33);
    for (int k = 0; k < 2; k++) begin
      tick();
      obs = sample();
      checks++;
      if (obs !== expa) begin
        errors++; $display("FAIL stall_hold got %h exp %h", obs, expa);
      end
    end
    bus.flush = 1;
    tick();
    expa.v = 1'b0;
    obs = sample();
    checks++;
    if (obs.v !== 1'b0) begin
      errors++; $display("FAIL flush_valid got %b exp 0", obs.v);
    end
    bus.flush = 0; bus.stall = 0; bus.in_valid = 0;
    tick();
    obs = sample();
    checks++;
    if (obs.v !== 1'b0 || obs.addr !== expa.addr) begin
      errors++; $display("FAIL b_absent got v%b addr %h exp v0 addr %h", obs.v, obs.addr, expa.addr);
    end
  endtask

  task automatic test_back_to_back();
    res_t obs, exp;
    logic go;
    logic [31:0] r;
    for (int k = 0; k < 80; k++) begin
      go = ($urandom_range(3) != 0);
      if (go) begin
        r = $urandom;
        put(1'($urandom_range(1)), 2'($urandom_range(3)),
            1'($urandom_range(1)), $urandom, $urandom,
            {{20{r[11]}}, r[11:0]}, 5'($urandom), 6'($urandom));
      end else begin
        bus.in_valid = 0;
      end
      tick();
      obs = sample();
      checks++;
      if (go) begin
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_queue got empty exp entry");
        end else begin
          exp = q.pop_front();
          if (obs !== exp) begin
            errors++; $display("FAIL b2b got %h exp %h", obs, exp);
          end
        end
      end else if (obs.v !== 1'b0) begin
        errors++; $display("FAIL b2b_idle got %b exp 0", obs.v);
      end
    end
    bus.in_valid = 0;
  endtask

  task automatic test_async_reset();
    res_t obs, exp;
    put(1, 2'b00, 0, 32'h5001, 32'h000000EE, 32'h0, 5'd20, 6'd1);
    tick();
    bus.in_valid = 0;
    exp = q.pop_front();
    obs = sample();
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL pre_rst got %h exp %h", obs, exp);
    end
    #2 rst = 1'b1;
    #1;
    obs = sample();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL async_rst got %h exp 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_flush();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL queue_left got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
